// File: rtl/keypad_reader_pkg.sv
// Shared constants, frame classes and the key map for the matrix keypad reader.
package keypad_reader_pkg;

  localparam int KEY_ROWS = 4;
  localparam int KEY_COLS = 4;
  localparam int KEY_NUM  = KEY_ROWS * KEY_COLS;

  localparam int KEY_RD_VALID_BIT = 15;
  localparam int KEY_RD_OVR_BIT   = 14;

  typedef enum logic [1:0] {
    CLS_NONE  = 2'd0,
    CLS_KEY   = 2'd1,
    CLS_MULTI = 2'd2
  } key_cls_e;

  typedef struct packed {
    key_cls_e   cls;
    logic [3:0] idx;
  } frame_cls_t;

  localparam frame_cls_t FRAME_NONE = '{cls: CLS_NONE, idx: 4'd0};

  // idx is forced to 0 for NONE and MULTI so whole-struct compares are meaningful
  function automatic frame_cls_t classify(input logic [KEY_NUM-1:0] pressed);
    frame_cls_t r;
    int         n;
    r = FRAME_NONE;
    n = 0;
    for (int i = 0; i < KEY_NUM; i++) begin
      if (pressed[i]) begin
        n++;
        r.idx = 4'(i);
      end
    end
    if (n == 1) begin
      r.cls = CLS_KEY;
    end else if (n > 1) begin
      r.cls = CLS_MULTI;
      r.idx = 4'd0;
    end else begin
      r.idx = 4'd0;
    end
    return r;
  endfunction

  // Row-major layout: 1 2 3 A / 4 5 6 B / 7 8 9 C / * 0 # D with * -> E, # -> F
  function automatic logic [3:0] keymap(input logic [3:0] idx);
    logic [3:0] c;
    case (idx)
      4'd0:    c = 4'h1;
      4'd1:    c = 4'h2;
      4'd2:    c = 4'h3;
      4'd3:    c = 4'hA;
      4'd4:    c = 4'h4;
      4'd5:    c = 4'h5;
      4'd6:    c = 4'h6;
      4'd7:    c = 4'hB;
      4'd8:    c = 4'h7;
      4'd9:    c = 4'h8;
      4'd10:   c = 4'h9;
      4'd11:   c = 4'hC;
      4'd12:   c = 4'hE;
      4'd13:   c = 4'h0;
      4'd14:   c = 4'hF;
      default: c = 4'hD;
    endcase
    return c;
  endfunction

endpackage

// File: rtl/keypad_row_scan.sv
// Row driver, column synchronizer and per-frame pressed-key vector capture.
module keypad_row_scan
  import keypad_reader_pkg::*;
#(
  parameter int SCAN_DIV = 10000
) (
  input  logic                clock,
  input  logic                reset,
  input  logic [KEY_COLS-1:0] col,
  output logic [KEY_ROWS-1:0] row,
  output logic                frame_done,
  output logic [KEY_NUM-1:0]  frame_vec
);

  localparam int DIV_W = (SCAN_DIV > 1) ? $clog2(SCAN_DIV) : 1;
  localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(SCAN_DIV - 1);
  localparam int IDX_W = $clog2(KEY_ROWS);
  localparam logic [IDX_W-1:0] IDX_LAST = IDX_W'(KEY_ROWS - 1);

  logic [KEY_COLS-1:0]         r_col_meta;
  logic [KEY_COLS-1:0]         r_col_sync;
  logic [DIV_W-1:0]            r_div;
  logic [IDX_W-1:0]            r_idx;
  logic [KEY_ROWS-1:0]         r_row;
  logic [KEY_NUM-KEY_COLS-1:0] r_acc;
  logic                        r_frame_done;
  logic [KEY_NUM-1:0]          r_frame_vec;

  logic [IDX_W-1:0]            w_idx_next;
  logic [KEY_COLS-1:0]         w_pressed;

  assign w_idx_next = r_idx + 1'b1;
  assign w_pressed  = ~r_col_sync;

  always_ff @(posedge clock) begin
    if (reset) begin
      r_col_meta   <= '1;
      r_col_sync   <= '1;
      r_div        <= '0;
      r_idx        <= '0;
      r_row        <= {{(KEY_ROWS-1){1'b1}}, 1'b0};
      r_acc        <= '0;
      r_frame_done <= 1'b0;
      r_frame_vec  <= '0;
    end else begin
      r_col_meta   <= col;
      r_col_sync   <= r_col_meta;
      r_frame_done <= 1'b0;
      if (r_div == DIV_LAST) begin
        r_div <= '0;
        r_idx <= w_idx_next;
        r_row <= ~(KEY_ROWS'(1) << w_idx_next);
        // last row completes the frame directly; earlier rows are parked in r_acc
        if (r_idx == IDX_LAST) begin
          r_frame_done <= 1'b1;
          r_frame_vec  <= {w_pressed, r_acc};
        end else begin
          for (int r = 0; r < KEY_ROWS - 1; r++) begin
            if (r_idx == IDX_W'(r)) r_acc[r*KEY_COLS +: KEY_COLS] <= w_pressed;
          end
        end
      end else begin
        r_div <= r_div + 1'b1;
      end
    end
  end

  assign row        = r_row;
  assign frame_done = r_frame_done;
  assign frame_vec  = r_frame_vec;

endmodule

// File: rtl/keypad_reader.sv
// 4x4 keypad reader: frame debounce, one latched code per press, read-to-clear status.
module keypad_reader
  import keypad_reader_pkg::*;
#(
  parameter int SCAN_DIV        = 10000,
  parameter int DEBOUNCE_FRAMES = 4
) (
  input  logic                clock,
  input  logic                reset,
  output logic [KEY_ROWS-1:0] row,
  input  logic [KEY_COLS-1:0] col,
  input  logic                ior,
  input  logic                keyctrl,
  output logic [15:0]         rd_data,
  output logic                key_valid
);

  localparam int CNT_W = $clog2(DEBOUNCE_FRAMES + 1);
  localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(DEBOUNCE_FRAMES);

  logic               w_frame_done;
  logic [KEY_NUM-1:0] w_frame_vec;
  frame_cls_t         w_cur;
  logic [CNT_W-1:0]   w_cnt_next;
  logic               w_accept;
  logic               w_event;
  logic               w_rd;

  frame_cls_t         r_prev;
  frame_cls_t         r_stable;
  logic [CNT_W-1:0]   r_cnt;
  logic               r_valid;
  logic               r_ovr;
  logic [3:0]         r_code;

  keypad_row_scan #(
    .SCAN_DIV (SCAN_DIV)
  ) u_scan (
    .clock      (clock),
    .reset      (reset),
    .col        (col),
    .row        (row),
    .frame_done (w_frame_done),
    .frame_vec  (w_frame_vec)
  );

  assign w_rd  = ior & keyctrl;
  assign w_cur = classify(w_frame_vec);

  always_comb begin
    w_cnt_next = CNT_W'(1);
    if (w_cur == r_prev) begin
      w_cnt_next = (r_cnt == CNT_MAX) ? r_cnt : r_cnt + 1'b1;
    end
    w_accept = w_frame_done && (w_cur.cls != CLS_MULTI) &&
               (w_cnt_next == CNT_MAX) && (w_cur != r_stable);
    w_event  = w_accept && (w_cur.cls == CLS_KEY);
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      r_prev   <= FRAME_NONE;
      r_stable <= FRAME_NONE;
      r_cnt    <= '0;
      r_valid  <= 1'b0;
      r_ovr    <= 1'b0;
      r_code   <= '0;
    end else begin
      if (w_frame_done) begin
        r_prev <= w_cur;
        // ghosting frames break any run but never move the accepted state
        if (w_cur.cls == CLS_MULTI) begin
          r_cnt <= '0;
        end else begin
          r_cnt <= w_cnt_next;
          if (w_accept) r_stable <= w_cur;
        end
      end
      if (w_event) begin
        r_code  <= keymap(w_cur.idx);
        r_valid <= 1'b1;
        r_ovr   <= r_valid & ~w_rd;
      end else if (w_rd) begin
        r_valid <= 1'b0;
        r_ovr   <= 1'b0;
      end
    end
  end

  always_comb begin
    rd_data = 16'h0000;
    if (w_rd) begin
      rd_data[KEY_RD_VALID_BIT] = r_valid;
      rd_data[KEY_RD_OVR_BIT]   = r_ovr;
      rd_data[3:0]              = r_code;
    end
  end

  assign key_valid = r_valid;

endmodule

// File: tb/tb_keypad_reader.sv
// Self-checking bench for keypad_reader: directed frame table plus randomized frames vs a model.
module tb_keypad_reader;

  localparam int SD = 4;
  localparam int DF = 2;
  localparam int FRAME = 4 * SD;

  logic        clock;
  logic        reset;
  logic [3:0]  row;
  logic [3:0]  col;
  logic        ior;
  logic        keyctrl;
  logic [15:0] rd_data;
  logic        key_valid;
  logic [15:0] keys_r;

  int total;
  int bad;

  typedef struct {
    logic [15:0] keys;
    bit          rd_ev;
    bit          rd;
    bit          exp_v;
    logic [15:0] exp_rd;
  } vec_t;

  vec_t tbl[$];

  logic [3:0] kmap [16] = '{4'h1, 4'h2, 4'h3, 4'hA, 4'h4, 4'h5, 4'h6, 4'hB,
                            4'h7, 4'h8, 4'h9, 4'hC, 4'hE, 4'h0, 4'hF, 4'hD};

  int         hist[$];
  int         m_stable;
  bit         m_valid;
  bit         m_ovr;
  logic [3:0] m_code;

  keypad_reader #(
    .SCAN_DIV        (SD),
    .DEBOUNCE_FRAMES (DF)
  ) dut (
    .clock     (clock),
    .reset     (reset),
    .row       (row),
    .col       (col),
    .ior       (ior),
    .keyctrl   (keyctrl),
    .rd_data   (rd_data),
    .key_valid (key_valid)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  // Passive matrix: a pressed key shorts its column to a driven (low) row
  always_comb begin
    col = 4'hF;
    for (int r = 0; r < 4; r++) begin
      if (!row[r]) col = col & ~keys_r[r*4 +: 4];
    end
  end

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  task automatic chk(input string name, input logic [15:0] got, input logic [15:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%h exp=%h", name, got, exp);
    end
  endtask

  task automatic add(input logic [15:0] k, input bit rev, input bit rd, input bit ev,
                     input logic [15:0] er);
    vec_t v;
    v.keys = k; v.rd_ev = rev; v.rd = rd; v.exp_v = ev; v.exp_rd = er;
    tbl.push_back(v);
  endtask

  // One 16-cycle frame, entered just after a frame-end edge; key_valid is
  // observed after the first edge (where the previous frame's event lands).
  task automatic run_frame(input logic [15:0] k, input bit rd_ev, input bit do_rd,
                           output bit got_v, output logic [15:0] got_rd);
    keys_r = k;
    got_rd = 16'h0;
    if (rd_ev) begin ior = 1'b1; keyctrl = 1'b1; end
    tick();
    ior = 1'b0; keyctrl = 1'b0;
    got_v = key_valid;
    tick();
    if (do_rd) begin
      ior = 1'b1; keyctrl = 1'b1;
      #1;
      got_rd = rd_data;
      tick();
      ior = 1'b0; keyctrl = 1'b0;
      repeat (FRAME - 3) tick();
    end else begin
      repeat (FRAME - 2) tick();
    end
  endtask

  task automatic check_rows(input string tag);
    logic [3:0] exp_row;
    for (int i = 0; i < FRAME; i++) begin
      exp_row = 4'hF;
      exp_row[i / SD] = 1'b0;
      chk($sformatf("%s_row_c%0d", tag, i), {12'h0, row}, {12'h0, exp_row});
      tick();
    end
  endtask

  function automatic int cls_of(input logic [15:0] k);
    if ($countones(k) == 0) return -1;
    if ($countones(k) > 1) return 99;
    for (int i = 0; i < 16; i++) if (k[i]) return i;
    return -1;
  endfunction

  // A class is accepted once the last DF frames all show it (ghost frames never do)
  task automatic model_frame(input logic [15:0] k);
    int  c;
    bit  same;
    c = cls_of(k);
    hist.push_back(c);
    if (hist.size() > DF) void'(hist.pop_front());
    same = (hist.size() == DF);
    foreach (hist[i]) if (hist[i] != c) same = 0;
    if (same && c != 99 && c != m_stable) begin
      m_stable = c;
      if (c >= 0) begin
        m_ovr   = m_valid;
        m_valid = 1'b1;
        m_code  = kmap[c];
      end
    end
  endtask

  initial begin
    bit          gv;
    logic [15:0] gr;
    logic [15:0] k;
    logic [15:0] prev_k;
    bit          do_rd;
    int          a;
    int          b;

    total = 0; bad = 0;
    reset = 1'b1; ior = 1'b0; keyctrl = 1'b0; keys_r = 16'h0;
    repeat (3) tick();
    chk("rst_row", {12'h0, row}, 16'h000E);
    chk("rst_valid", {15'h0, key_valid}, 16'h0);
    reset = 1'b0;
    ior = 1'b1; keyctrl = 1'b1; #1;
    chk("rst_rd", rd_data, 16'h0000);
    ior = 1'b0; keyctrl = 1'b0;
    check_rows("idle");
    chk("idle_valid", {15'h0, key_valid}, 16'h0);

    add(16'h0040, 0, 0, 0, 16'h0);
    add(16'h0040, 0, 0, 0, 16'h0);
    add(16'h0040, 0, 1, 1, 16'h8006);
    for (int i = 0; i < 10; i++) add(16'h0040, 0, 0, 0, 16'h0);
    add(16'h0000, 0, 0, 0, 16'h0);
    add(16'h0000, 0, 0, 0, 16'h0);
    add(16'h2000, 0, 0, 0, 16'h0);
    add(16'h2000, 0, 0, 0, 16'h0);
    add(16'h0000, 0, 0, 1, 16'h0);
    add(16'h0000, 0, 0, 1, 16'h0);
    add(16'h0000, 0, 0, 1, 16'h0);
    add(16'h2000, 0, 0, 1, 16'h0);
    add(16'h2000, 0, 0, 1, 16'h0);
    add(16'h2000, 0, 1, 1, 16'hC000);
    add(16'h2000, 0, 0, 0, 16'h0);
    add(16'h0003, 0, 0, 0, 16'h0);
    add(16'h0003, 0, 0, 0, 16'h0);
    add(16'h0003, 0, 0, 0, 16'h0);
    add(16'h0001, 0, 0, 0, 16'h0);
    add(16'h0001, 0, 0, 0, 16'h0);
    add(16'h0001, 0, 1, 1, 16'h8001);
    add(16'h0020, 0, 0, 0, 16'h0);
    add(16'h0000, 0, 0, 0, 16'h0);
    add(16'h0020, 0, 0, 0, 16'h0);
    add(16'h0000, 0, 0, 0, 16'h0);
    add(16'h0020, 0, 0, 0, 16'h0);
    add(16'h0020, 0, 0, 0, 16'h0);
    add(16'h0020, 0, 1, 1, 16'h8005);
    add(16'h0000, 0, 0, 0, 16'h0);
    add(16'h0000, 0, 0, 0, 16'h0);
    add(16'h0400, 0, 0, 0, 16'h0);
    add(16'h0400, 0, 0, 0, 16'h0);
    add(16'h0000, 0, 0, 1, 16'h0);
    add(16'h0000, 0, 0, 1, 16'h0);
    add(16'h8000, 0, 0, 1, 16'h0);
    add(16'h8000, 0, 0, 1, 16'h0);
    add(16'h8000, 1, 1, 1, 16'h800D);
    add(16'h0000, 0, 0, 0, 16'h0);
    add(16'h0000, 0, 0, 0, 16'h0);
    add(16'h0008, 0, 0, 0, 16'h0);
    add(16'h0008, 0, 0, 0, 16'h0);
    add(16'h0000, 0, 0, 1, 16'h0);

    foreach (tbl[i]) begin
      run_frame(tbl[i].keys, tbl[i].rd_ev, tbl[i].rd, gv, gr);
      chk($sformatf("tbl%0d_valid", i), {15'h0, gv}, {15'h0, tbl[i].exp_v});
      if (tbl[i].rd) chk($sformatf("tbl%0d_rd", i), gr, tbl[i].exp_rd);
    end

    // Reset in the middle of a frame with an unread key pending
    repeat (6) tick();
    reset = 1'b1;
    tick();
    chk("midrst_row", {12'h0, row}, 16'h000E);
    chk("midrst_valid", {15'h0, key_valid}, 16'h0);
    ior = 1'b1; keyctrl = 1'b1; #1;
    chk("midrst_rd", rd_data, 16'h0000);
    ior = 1'b0; keyctrl = 1'b0;
    keys_r = 16'h0;
    reset = 1'b0;
    check_rows("post");

    hist = {-1};
    m_stable = -1; m_valid = 1'b0; m_ovr = 1'b0; m_code = 4'h0;
    prev_k = 16'h0;
    for (int f = 0; f < 150; f++) begin
      a = $urandom_range(0, 9);
      if (a < 5) k = prev_k;
      else if (a < 7) k = 16'h0;
      else if (a < 9) k = 16'h1 << $urandom_range(0, 15);
      else begin
        a = $urandom_range(0, 15);
        b = (a + 1 + $urandom_range(0, 14)) % 16;
        k = (16'h1 << a) | (16'h1 << b);
      end
      prev_k = k;
      do_rd = ($urandom_range(0, 9) < 3);
      run_frame(k, 1'b0, do_rd, gv, gr);
      chk($sformatf("rnd%0d_valid", f), {15'h0, gv}, {15'h0, m_valid});
      if (do_rd) begin
        chk($sformatf("rnd%0d_rd", f), gr, {m_valid, m_ovr, 10'h0, m_code});
        m_valid = 1'b0;
        m_ovr   = 1'b0;
      end
      model_frame(k);
      if (f % 10 == 0) begin
        ior = 1'b1; keyctrl = 1'b0; #1;
        chk($sformatf("rnd%0d_nosel", f), rd_data, 16'h0000);
        ior = 1'b0;
      end
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
